// File: rtl/dp_sequencer_if.sv
// dp_sequencer_if
// Instruction-memory fetch bus between the sequencer and instruction memory.
//   imem_req   : fetch request, driven by the sequencer (master)
//   imem_ack   : acknowledge, driven by memory (slave)
//   imem_rdata : 16-bit instruction word, valid when imem_ack=1
interface dp_sequencer_if;
  logic        imem_req;
  logic        imem_ack;
  logic [15:0] imem_rdata;

  modport master (output imem_req, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, output imem_ack, output imem_rdata);
endinterface

// File: rtl/dp_sequencer.sv
// dp_sequencer
// Multi-cycle control FSM for the 4-bit datapath (PC, 4x4 register file, ALU).
// Fetches an instruction over the imem bus, latches it in IR, then walks
// DECODE -> READ -> EXEC -> WB, driving register-file and ALU controls.
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   start       : begin execution (sampled only in IDLE)
//   imem        : fetch bus (master side: imem_req out, imem_ack/imem_rdata in)
//   ir          : instruction register
//   rf_rw       : register file control, 1=read 0=write
//   alu_op      : ALU operation, alu_sub : subtract select
//   pc_inc      : one-cycle PC increment pulse
//   busy        : executing (FETCH..WB)
//   halted      : halt executed (sticky), error : fetch timeout (sticky)
//   instr_count : retired instructions, saturating
module dp_sequencer #(
  parameter int TIMEOUT = 15,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  dp_sequencer_if.master     imem,
  output logic [15:0]        ir,
  output logic               rf_rw,
  output logic [1:0]         alu_op,
  output logic               alu_sub,
  output logic               pc_inc,
  output logic               busy,
  output logic               halted,
  output logic               error,
  output logic [COUNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_READ   = 3'd3,
    S_EXEC   = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  localparam logic [7:0]         TIMEOUT_LAST = 8'(TIMEOUT - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX    = '1;

  state_t     state, state_next;
  logic [7:0] timeout_cnt;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // An ack on the last allowed FETCH cycle is checked first so it beats the timeout.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_FETCH;
      S_FETCH: begin
        if (imem.imem_ack)                   state_next = S_DECODE;
        else if (timeout_cnt == TIMEOUT_LAST) state_next = S_ERROR;
      end
      S_DECODE: state_next = ir[15] ? S_HALT : S_READ;
      S_READ:   state_next = S_EXEC;
      S_EXEC:   state_next = S_WB;
      S_WB:     state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      S_ERROR:  state_next = S_ERROR;
      default:  state_next = S_IDLE;
    endcase
  end

  // The timeout counter is held at zero outside FETCH, which clears it on every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir          <= '0;
      timeout_cnt <= '0;
      alu_op      <= '0;
      alu_sub     <= 1'b0;
      instr_count <= '0;
    end else begin
      if (state == S_FETCH && !imem.imem_ack) timeout_cnt <= timeout_cnt + 8'd1;
      else                                    timeout_cnt <= '0;

      if (state == S_FETCH && imem.imem_ack) ir <= imem.imem_rdata;

      if (state == S_DECODE) begin
        alu_op  <= ir[7:6];
        alu_sub <= ir[8];
      end

      if (state == S_WB && instr_count != COUNT_MAX) instr_count <= instr_count + 1'b1;
    end
  end

  // Moore outputs decoded from the state register and IR only.
  always_comb begin
    imem.imem_req = (state == S_FETCH);
    rf_rw         = !(state == S_WB && !ir[14]);
    pc_inc        = (state == S_WB);
    busy          = (state == S_FETCH) || (state == S_DECODE) || (state == S_READ) ||
                    (state == S_EXEC)  || (state == S_WB);
    halted        = (state == S_HALT);
    error         = (state == S_ERROR);
  end

endmodule

// File: tb/tb_dp_sequencer.sv
// tb_dp_sequencer
// Self-checking bench for dp_sequencer. Drives the instruction-memory side of
// the fetch bus and checks every cycle against a transaction-level model:
// an instruction fetched after d wait cycles occupies d+1 request cycles,
// then decode, read, exec and writeback, retiring one instruction.
module tb_dp_sequencer;

  localparam int TIMEOUT = 15;
  localparam int COUNT_W = 8;
  localparam int COUNT_MAX = (1 << COUNT_W) - 1;

  logic               clk;
  logic               rst;
  logic               start;
  logic [15:0]        ir;
  logic               rf_rw;
  logic [1:0]         alu_op;
  logic               alu_sub;
  logic               pc_inc;
  logic               busy;
  logic               halted;
  logic               error;
  logic [COUNT_W-1:0] instr_count;

  dp_sequencer_if bus ();

  dp_sequencer #(.TIMEOUT(TIMEOUT), .COUNT_W(COUNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .imem        (bus.master),
    .ir          (ir),
    .rf_rw       (rf_rw),
    .alu_op      (alu_op),
    .alu_sub     (alu_sub),
    .pc_inc      (pc_inc),
    .busy        (busy),
    .halted      (halted),
    .error       (error),
    .instr_count (instr_count)
  );

  int checks = 0;
  int errors = 0;
  int retired = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int expCount();
    return (retired > COUNT_MAX) ? COUNT_MAX : retired;
  endfunction

  task automatic applyStimulus(input logic s, input logic ack, input logic [15:0] rdata);
    start          = s;
    bus.imem_ack   = ack;
    bus.imem_rdata = rdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic checkAll(input string tag, input bit e_req, input bit e_rf, input bit e_pc,
                          input bit e_busy, input bit e_halt, input bit e_err, input int e_cnt);
    checkOutput({tag, ".imem_req"},    32'(bus.imem_req), 32'(e_req));
    checkOutput({tag, ".rf_rw"},       32'(rf_rw),        32'(e_rf));
    checkOutput({tag, ".pc_inc"},      32'(pc_inc),       32'(e_pc));
    checkOutput({tag, ".busy"},        32'(busy),         32'(e_busy));
    checkOutput({tag, ".halted"},      32'(halted),       32'(e_halt));
    checkOutput({tag, ".error"},       32'(error),        32'(e_err));
    checkOutput({tag, ".instr_count"}, 32'(instr_count),  32'(e_cnt));
  endtask

  task automatic checkResetState(input string tag);
    checkAll(tag, 0, 1, 0, 0, 0, 0, 0);
    checkOutput({tag, ".ir"},      32'(ir),      32'h0);
    checkOutput({tag, ".alu_op"},  32'(alu_op),  32'h0);
    checkOutput({tag, ".alu_sub"}, 32'(alu_sub), 32'h0);
  endtask

  // Synchronous reset applied across one edge; model forgets retired work.
  task automatic doReset(input string tag);
    rst = 1'b1;
    applyStimulus(0, 0, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    retired = 0;
    checkResetState(tag);
  endtask

  // Called at a negedge in IDLE: request start for the coming edge.
  task automatic kick();
    applyStimulus(1, 0, 16'h0);
  endtask

  // One instruction starting from the first FETCH cycle. abort: 0 none,
  // 1 reset on the ack cycle of fetch, 2 reset during writeback.
  task automatic runInstr(input logic [15:0] instr, input int delay, input int abort);
    for (int k = 0; k <= delay; k++) begin
      @(negedge clk);
      checkAll("fetch", 1, 1, 0, 1, 0, 0, expCount());
      if (k == delay && abort == 1) begin
        rst = 1'b1;
        applyStimulus(0, 1, instr);
        @(negedge clk);
        rst = 1'b0;
        retired = 0;
        applyStimulus(0, 0, 16'h0);
        checkResetState("rst_fetch");
        return;
      end
      if (k == delay) applyStimulus(0, 1, instr);
      else            applyStimulus(0, 0, 16'($urandom));
    end
    @(negedge clk);
    checkAll("decode", 0, 1, 0, 1, 0, 0, expCount());
    checkOutput("decode.ir", 32'(ir), 32'(instr));
    applyStimulus(0, 1, ~instr);
    if (instr[15]) begin
      @(negedge clk);
      applyStimulus(0, 0, 16'h0);
      checkAll("halt", 0, 1, 0, 0, 1, 0, expCount());
      return;
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      applyStimulus(0, 0, 16'($urandom));
      checkAll("rdex", 0, 1, 0, 1, 0, 0, expCount());
      checkOutput("rdex.ir",      32'(ir),      32'(instr));
      checkOutput("rdex.alu_op",  32'(alu_op),  32'(instr[7:6]));
      checkOutput("rdex.alu_sub", 32'(alu_sub), 32'(instr[8]));
    end
    @(negedge clk);
    checkAll("wb", 0, instr[14], 1, 1, 0, 0, expCount());
    if (abort == 2) begin
      rst = 1'b1;
      applyStimulus(0, 0, 16'h0);
      @(negedge clk);
      rst = 1'b0;
      retired = 0;
      checkResetState("rst_wb");
      return;
    end
    applyStimulus(0, 0, 16'h0);
    retired++;
  endtask

  initial begin
    logic [15:0] rnd;
    $display("[TB] starting dp_sequencer bench");
    rst = 1'b1;
    applyStimulus(0, 0, 16'h0);
    @(negedge clk);
    @(negedge clk);
    doReset("reset");

    // IDLE holds without start.
    @(negedge clk);
    checkAll("idle", 0, 1, 0, 0, 0, 0, 0);
    kick();

    // ADD, SUB, no-write ADD back to back.
    runInstr(16'h00A4, 0, 0);
    runInstr(16'h01A4, 0, 0);
    runInstr(16'h40A4, 0, 0);
    // Ack after 3 wait cycles, and on the final allowed cycle.
    runInstr({1'b0, 15'($urandom)}, 3, 0);
    runInstr({1'b0, 15'($urandom)}, TIMEOUT - 1, 0);

    // Randomized instruction stream with random ack latency.
    for (int n = 0; n < 25; n++) begin
      rnd = 16'($urandom);
      rnd[15] = 1'b0;
      runInstr(rnd, int'($urandom_range(0, TIMEOUT - 1)), 0);
    end

    // Halt: no retirement, start ignored afterwards.
    runInstr(16'h8000, int'($urandom_range(0, 4)), 0);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      checkAll("halt_hold", 0, 1, 0, 0, 1, 0, expCount());
      applyStimulus(n[0], 1, 16'h00A4);
    end

    // Fetch timeout.
    doReset("reset2");
    kick();
    for (int k = 0; k < TIMEOUT; k++) begin
      @(negedge clk);
      checkAll("to_fetch", 1, 1, 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 16'h0);
    end
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      checkAll("to_error", 0, 1, 0, 0, 0, 1, 0);
      applyStimulus(n[0], 1, 16'h00A4);
    end

    // Reset mid-fetch with ack high, then reset during writeback.
    doReset("reset3");
    kick();
    runInstr(16'h00A4, 0, 1);
    @(negedge clk);
    checkAll("after_rst_fetch", 0, 1, 0, 0, 0, 0, 0);
    kick();
    runInstr(16'h00A4, 0, 0);
    runInstr(16'h00A4, 1, 2);
    @(negedge clk);
    checkAll("after_rst_wb", 0, 1, 0, 0, 0, 0, 0);

    // Retired counter saturation.
    kick();
    for (int n = 0; n < 300; n++) begin
      rnd = 16'($urandom);
      rnd[15] = 1'b0;
      runInstr(rnd, 0, 0);
    end
    @(negedge clk);
    checkOutput("saturate", 32'(instr_count), 32'(COUNT_MAX));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
